core_frame_receiver: RTL and testbench
======================================

Name: core_frame_receiver

Overview:
- Core-side end of the scheduler frame bus; one instance per core, with a CORE_ID parameter.
- Parses the broadcast task stream one 16-bit frame per handshake:
  - 3 control frames;
  - R0_DEPTH R0 frames;
  - N×16 instruction frames.
- Tracks every task on the bus. Only when its own bit is set in the core mask does it capture R0, write instructions into the core's instruction memory and launch the core.
- Produces the per-core core_ready bit and the core_reading handshake bit that the scheduler consumes.

Parameters:
- CORE_ID, 0, index of this core's bit in the core mask (0..CORE_NUM-1)
- CORE_NUM, 16, mask width
- FRAME_SIZE, 16, bus frame width
- R0_DEPTH, 8, number of R0 frames; R0 data = R0_DEPTH*FRAME_SIZE = 128 bits
- IMEM_DEPTH, 1024, instruction memory words (16-bit each)
- CNT_W, 10, frame counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- frame_in  in  16  frame bus from scheduler
- frame_being_sent  in  1  frame_in valid
- core_reading  out  1  receiver accepts frame this cycle
- core_ready  out  1  this core idle and able to take a task
- imem_we  out  1  instruction write strobe
- imem_addr  out  10  instruction write address
- imem_wdata  out  16  instruction word
- imem_ready  in  1  imem can accept a write this cycle
- r0_data  out  128  captured R0 block, frame 0 in bits [15:0]
- task_hold  out  1  loaded task waiting for go (ctrl bit 6)
- task_barrier  out  1  ctrl bit 7 of current task
- core_start  out  1  one-cycle launch pulse
- go  in  1  releases a held task
- core_done  in  1  one-cycle pulse, core finished task
- err_mask  out  1  one-cycle pulse, mask frames mismatch
- err_busy  out  1  sticky, addressed while busy; cleared by reset

Behaviour:
- Transfer happens when frame_being_sent && core_reading. Both must be high on the same posedge; otherwise the state holds.
- core_reading = 0 in reset. It is low in INSTR when addressed && !imem_ready. It is 1 in every other state.
- Ctrl frame layout:
  - [5:0] LEN = number of instruction blocks of 16 frames;
  - [6] HOLD;
  - [7] BARRIER;
  - [15:8] ignored.
- Reset values:
  - state IDLE; core_ready=1; all pulses 0; imem_we=0; imem_addr=0; r0_data=0;
  - task_hold=0; task_barrier=0; err_busy=0; counters 0.
- FSM states and transitions:
  - IDLE/HDR: a transfer latches ctrl → MASK1.
  - MASK1: a transfer latches mask1, and addressed = mask1[CORE_ID] → MASK2.
  - MASK2: a transfer compares with mask1.
    - Mismatch: pulse err_mask next cycle, force addressed=0, go to SKIP for the rest of the task.
    - Match: go to R0.
    - If addressed && !core_ready: set err_busy and force addressed=0.
  - R0: R0_DEPTH transfers. When addressed, frame k goes to r0_data[16k+15:16k]. Then:
    - LEN=0 → DONE;
    - otherwise → INSTR.
  - INSTR: LEN*16 transfers. When addressed:
    - imem_we=1, imem_wdata=frame, imem_addr=count, registered in the cycle after the transfer;
    - address starts at 0 each task; writes beyond IMEM_DEPTH-1 are dropped (no wrap).
    - Last frame → DONE.
  - SKIP: not-addressed tasks walk the same counts through R0/INSTR with no writes and no captures.
  - DONE (1 cycle):
    - addressed && !HOLD → pulse core_start, core_ready←0 → IDLE;
    - addressed && HOLD → task_hold=1 → IDLE;
    - not addressed → IDLE.
  - Held task: go with task_hold=1 → core_start pulse next cycle, task_hold←0, core_ready←0.
- core_done → core_ready←1 next cycle.
  - core_done is ignored if core_ready is already 1.
  - Parsing of bus tasks continues while the core is busy.
- task_barrier is latched from ctrl on addressed tasks and held until the next addressed task.
- Simultaneous events: core_done and the MASK2 transfer in the same cycle → the core is treated as ready (no err_busy).
- Reset mid-task: immediate return to reset values; the partial task is discarded and no start is issued.
- Latency: core_start is asserted 2 cycles after the final frame transfer.

Decomposition:
- Package gpu_frame_pkg holds:
  - FRAME_SIZE;
  - ctrl bit positions (LEN_LSB=0, LEN_W=6, HOLD_BIT=6, BARRIER_BIT=7);
  - CTRL_FRAMES=3;
  - the FSM state enum.
- One natural sub-module: frame_counter (loadable down-counter with last flag). It is used by both the R0 and INSTR phases.

Test Plan:
- ctrl 0x0003, masks 0x000f/0x000f, CORE_ID=0, 8 R0 frames, 48 instr frames → imem_we 48 times at addr 0..47; r0_data matches; core_start 2 cycles after the last frame; core_ready=0 until core_done.
- Same task with CORE_ID=4 → zero imem_we, no core_start, core_ready stays 1; returns to IDLE after 59 transfers.
- ctrl 0x0043 addressed → task_hold=1 with no start; go → core_start next cycle.
- masks 0x00f0/0x00f1 → err_mask pulse; next task parsed correctly from its header.
- Addressed task 0x0007 while busy → err_busy=1, no writes; back-to-back with core_done in the MASK2 cycle → accepted.
- imem_ready low for 5 cycles mid-INSTR → core_reading low, no frames lost; reset mid-INSTR → outputs reset, no core_start.

Source files
------------

// File: rtl/gpu_frame_pkg.sv
// Shared definitions for the scheduler frame bus: frame width, control-frame
// field positions and the receiver FSM state encoding.
package gpu_frame_pkg;

    localparam int unsigned FRAME_SIZE  = 16;

    // Control frame fields
    localparam int unsigned LEN_LSB     = 0;
    localparam int unsigned LEN_W       = 6;
    localparam int unsigned HOLD_BIT    = 6;
    localparam int unsigned BARRIER_BIT = 7;

    // Header = ctrl + two copies of the core mask
    localparam int unsigned CTRL_FRAMES = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MASK1,
        ST_MASK2,
        ST_R0,
        ST_INSTR,
        ST_SKIP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/frame_counter.sv
// Loadable down-counter that flags the final frame of a phase.
// Ports: clk/reset; load + load_val preset the count (load wins over dec);
// dec consumes one frame; last_c is high while exactly one frame remains.
module frame_counter #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last_c
);

    logic [CNT_W-1:0] count;

    // Remaining-frame count for the current phase
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign last_c = (count == CNT_W'(1));

endmodule

// File: rtl/core_frame_receiver.sv
// Core-side receiver for the broadcast scheduler frame bus. Follows every task
// on the bus (ctrl, mask, mask, R0 block, instruction blocks) and, when this
// core's mask bit is set, captures R0, writes instructions to imem and
// launches the core.
// Ports:
//   clk, reset (sync, active-high)
//   frame_in/frame_being_sent/core_reading : bus handshake (core_reading is
//       combinational so an imem stall back-pressures the bus in the same cycle)
//   imem_we/imem_addr/imem_wdata/imem_ready : instruction memory write port
//   r0_data : captured R0 block, frame 0 in the low bits
//   core_ready/core_start/core_done/go/task_hold/task_barrier : core control
//   err_mask (pulse), err_busy (sticky) : error reporting
module core_frame_receiver #(
    parameter int unsigned CORE_ID    = 0,
    parameter int unsigned CORE_NUM   = 16,
    parameter int unsigned FRAME_SIZE = gpu_frame_pkg::FRAME_SIZE,
    parameter int unsigned R0_DEPTH   = 8,
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned CNT_W      = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [FRAME_SIZE-1:0]          frame_in,
    input  logic                           frame_being_sent,
    output logic                           core_reading,
    output logic                           core_ready,
    output logic                           imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0]  imem_addr,
    output logic [FRAME_SIZE-1:0]          imem_wdata,
    input  logic                           imem_ready,
    output logic [R0_DEPTH*FRAME_SIZE-1:0] r0_data,
    output logic                           task_hold,
    output logic                           task_barrier,
    output logic                           core_start,
    input  logic                           go,
    input  logic                           core_done,
    output logic                           err_mask,
    output logic                           err_busy
);

    import gpu_frame_pkg::state_t, gpu_frame_pkg::ST_IDLE, gpu_frame_pkg::ST_MASK1,
           gpu_frame_pkg::ST_MASK2, gpu_frame_pkg::ST_R0, gpu_frame_pkg::ST_INSTR,
           gpu_frame_pkg::ST_SKIP, gpu_frame_pkg::ST_DONE, gpu_frame_pkg::LEN_LSB,
           gpu_frame_pkg::LEN_W, gpu_frame_pkg::HOLD_BIT, gpu_frame_pkg::BARRIER_BIT;

    localparam int unsigned ADDR_W = $clog2(IMEM_DEPTH);
    localparam int unsigned R0_W   = R0_DEPTH * FRAME_SIZE;

    state_t               state, next_state;
    logic [LEN_W-1:0]     len_q;
    logic                 hold_q;
    logic                 barrier_q;
    logic [CORE_NUM-1:0]  mask1_q;
    logic                 addressed;
    logic [ADDR_W:0]      wr_addr;

    logic                 xfer;
    logic                 mask_match;
    logic                 take_task;
    logic                 busy_hit;
    logic [CNT_W-1:0]     instr_frames;
    logic                 cnt_load;
    logic [CNT_W-1:0]     cnt_val;
    logic                 cnt_dec;
    logic                 cnt_last;

    // Only an addressed instruction phase can stall on imem
    assign core_reading = !reset && !((state == ST_INSTR) && addressed && !imem_ready);
    assign xfer         = frame_being_sent && core_reading;

    // A core_done landing on the second mask frame counts as ready
    assign mask_match   = (frame_in[CORE_NUM-1:0] == mask1_q);
    assign take_task    = mask_match && addressed && (core_ready || core_done);
    assign busy_hit     = mask_match && addressed && !core_ready && !core_done;
    assign instr_frames = CNT_W'({len_q, 4'b0000});

    frame_counter #(.CNT_W(CNT_W)) u_frame_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .last_c   (cnt_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and frame-counter control
    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_dec    = 1'b0;
        unique case (state)
            ST_IDLE:  if (xfer) next_state = ST_MASK1;
            ST_MASK1: if (xfer) next_state = ST_MASK2;
            ST_MASK2: begin
                if (xfer) begin
                    cnt_load = 1'b1;
                    if (take_task) begin
                        next_state = ST_R0;
                        cnt_val    = CNT_W'(R0_DEPTH);
                    end else begin
                        // Unclaimed tasks walk R0 and instructions as one run
                        next_state = ST_SKIP;
                        cnt_val    = CNT_W'(R0_DEPTH) + instr_frames;
                    end
                end
            end
            ST_R0: begin
                if (xfer) begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        if (len_q == '0) begin
                            next_state = ST_DONE;
                        end else begin
                            next_state = ST_INSTR;
                            cnt_load   = 1'b1;
                            cnt_val    = instr_frames;
                        end
                    end
                end
            end
            ST_INSTR, ST_SKIP: begin
                if (xfer) begin
                    cnt_dec = 1'b1;
                    if (cnt_last) next_state = ST_DONE;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Task capture, imem writes and core control
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q        <= '0;
            hold_q       <= 1'b0;
            barrier_q    <= 1'b0;
            mask1_q      <= '0;
            addressed    <= 1'b0;
            wr_addr      <= '0;
            core_ready   <= 1'b1;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            r0_data      <= '0;
            task_hold    <= 1'b0;
            task_barrier <= 1'b0;
            core_start   <= 1'b0;
            err_mask     <= 1'b0;
            err_busy     <= 1'b0;
        end else begin
            core_start <= 1'b0;
            err_mask   <= 1'b0;
            imem_we    <= 1'b0;

            if (core_done && !core_ready) core_ready <= 1'b1;

            if (xfer) begin
                unique case (state)
                    ST_IDLE: begin
                        len_q     <= frame_in[LEN_LSB +: LEN_W];
                        hold_q    <= frame_in[HOLD_BIT];
                        barrier_q <= frame_in[BARRIER_BIT];
                    end
                    ST_MASK1: begin
                        mask1_q   <= frame_in[CORE_NUM-1:0];
                        addressed <= frame_in[CORE_ID];
                    end
                    ST_MASK2: begin
                        wr_addr <= '0;
                        if (!mask_match) begin
                            err_mask  <= 1'b1;
                            addressed <= 1'b0;
                        end else if (busy_hit) begin
                            err_busy  <= 1'b1;
                            addressed <= 1'b0;
                        end else if (addressed) begin
                            task_barrier <= barrier_q;
                        end
                    end
                    ST_R0: begin
                        // Shift in from the top so frame 0 ends in the low bits
                        if (addressed) r0_data <= {frame_in, r0_data[R0_W-1:FRAME_SIZE]};
                    end
                    ST_INSTR: begin
                        if (addressed) begin
                            wr_addr <= wr_addr + (ADDR_W+1)'(1);
                            if (wr_addr < (ADDR_W+1)'(IMEM_DEPTH)) begin
                                imem_we    <= 1'b1;
                                imem_addr  <= wr_addr[ADDR_W-1:0];
                                imem_wdata <= frame_in;
                            end
                        end
                    end
                    default: ;
                endcase
            end

            if ((state == ST_DONE) && addressed) begin
                if (hold_q) begin
                    task_hold <= 1'b1;
                end else begin
                    core_start <= 1'b1;
                    core_ready <= 1'b0;
                end
            end

            if (go && task_hold) begin
                task_hold  <= 1'b0;
                core_start <= 1'b1;
                core_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_core_frame_receiver.sv
// Directed bench: two receivers (CORE_ID 0 and 4) watch one frame bus.
module tb_core_frame_receiver;

    typedef struct {
        logic [15:0] ctrl, m1, m2;
        int          we0, we4, st0, st4, em0, em4;
        logic        rdy0, bar0, chk_r0;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset, fbs, go, done0, done4, imem_rdy0;
    logic         imem_rdy4 = 1'b1;
    logic         go4 = 1'b0;
    logic [15:0]  frame;
    logic         fbs4;

    logic         rd0, ready0, we0, hold0, bar0, start0, errm0, errb0;
    logic [9:0]   addr0;
    logic [15:0]  wdata0;
    logic [127:0] r0d0;
    logic         rd4, ready4, we4, hold4, bar4, start4, errm4, errb4;
    logic [9:0]   addr4;
    logic [15:0]  wdata4;
    logic [127:0] r0d4;

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, last_xfer = 0, start0_cyc = 0, rd_low = 0, cur_row = 0;
    int we0_tot = 0, we4_tot = 0, st0_tot = 0, st4_tot = 0, em0_tot = 0, em4_tot = 0, bad_tot = 0;
    int b_we0 = 0, b_we4 = 0, b_st0 = 0, b_st4 = 0, b_em0 = 0, b_em4 = 0, b_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // The second receiver only sees frames the first one also accepts
    assign fbs4 = fbs && rd0;

    core_frame_receiver #(.CORE_ID(0)) dut0 (
        .clk(clk), .reset(reset), .frame_in(frame), .frame_being_sent(fbs),
        .core_reading(rd0), .core_ready(ready0), .imem_we(we0), .imem_addr(addr0),
        .imem_wdata(wdata0), .imem_ready(imem_rdy0), .r0_data(r0d0), .task_hold(hold0),
        .task_barrier(bar0), .core_start(start0), .go(go), .core_done(done0),
        .err_mask(errm0), .err_busy(errb0));

    core_frame_receiver #(.CORE_ID(4)) dut4 (
        .clk(clk), .reset(reset), .frame_in(frame), .frame_being_sent(fbs4),
        .core_reading(rd4), .core_ready(ready4), .imem_we(we4), .imem_addr(addr4),
        .imem_wdata(wdata4), .imem_ready(imem_rdy4), .r0_data(r0d4), .task_hold(hold4),
        .task_barrier(bar4), .core_start(start4), .go(go4), .core_done(done4),
        .err_mask(errm4), .err_busy(errb4));

    function automatic logic [15:0] r0_word(int row, int k);
        return 16'hA000 | 16'(row << 8) | 16'(k);
    endfunction

    function automatic logic [15:0] instr_word(int row, int i);
        return 16'(i * 7 + row * 256 + 1);
    endfunction

    function automatic logic [127:0] exp_r0(int row);
        logic [127:0] e;
        e = '0;
        for (int k = 0; k < 8; k++) e[16*k +: 16] = r0_word(row, k);
        return e;
    endfunction

    // Event monitor; dut0 writes are checked against the expected word stream
    always @(negedge clk) begin
        if (we0) begin
            if (addr0 != 10'(we0_tot - b_we0) || wdata0 != instr_word(cur_row, we0_tot - b_we0))
                bad_tot++;
            we0_tot++;
        end
        if (we4)    we4_tot++;
        if (start0) begin st0_tot++; start0_cyc = cyc; end
        if (start4) st4_tot++;
        if (errm0)  em0_tot++;
        if (errm4)  em4_tot++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_v(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic snap();
        b_we0 = we0_tot; b_we4 = we4_tot; b_st0 = st0_tot; b_st4 = st4_tot;
        b_em0 = em0_tot; b_em4 = em4_tot; b_bad = bad_tot;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        fbs = 1'b0; done0 = 1'b0; done4 = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    // One frame; waits (bounded) until both receivers accept it
    task automatic send_frame(input logic [15:0] f, input logic dn, input int stall);
        int waitc;
        waitc = 0;
        @(negedge clk);
        frame = f; fbs = 1'b1; done0 = dn; imem_rdy0 = (stall == 0);
        #1;
        while (!(rd0 && rd4)) begin
            if (!rd0) rd_low++;
            waitc++;
            if (waitc > 200) begin
                n_cmp++; n_fail++;
                $display("FAIL handshake_timeout: frame %h not accepted", f);
                imem_rdy0 = 1'b1;
                return;
            end
            @(negedge clk);
            if (waitc >= stall) imem_rdy0 = 1'b1;
            #1;
        end
        last_xfer = cyc;
        @(posedge clk);
    endtask

    task automatic send_task(input int row, input logic [15:0] ctrl, input logic [15:0] m1,
                             input logic [15:0] m2, input logic dn_m2, input int stall_at);
        cur_row = row;
        send_frame(ctrl, 1'b0, 0);
        send_frame(m1, 1'b0, 0);
        send_frame(m2, dn_m2, 0);
        for (int k = 0; k < 8; k++) send_frame(r0_word(row, k), 1'b0, 0);
        for (int i = 0; i < int'(ctrl[5:0]) * 16; i++)
            send_frame(instr_word(row, i), 1'b0, (i == stall_at) ? 5 : 0);
    endtask

    task automatic pulse_done();
        @(negedge clk); done0 = 1'b1; done4 = 1'b1;
        @(negedge clk); done0 = 1'b0; done4 = 1'b0;
        #1;
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{16'h0003, 16'h000f, 16'h000f, 48, 0, 1, 0, 0, 0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{16'h0003, 16'h0010, 16'h0010, 0, 48, 0, 1, 0, 0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h0000, 16'h0011, 16'h0011, 0, 0, 1, 1, 0, 0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'h0001, 16'h00f0, 16'h00f1, 0, 0, 0, 0, 1, 1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'h0081, 16'h0001, 16'h0001, 16, 0, 1, 0, 0, 0, 1'b0, 1'b1, 1'b1};

        reset = 1'b1; fbs = 1'b0; frame = '0; go = 1'b0; done0 = 1'b0; done4 = 1'b0;
        imem_rdy0 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_core_reading", int'(rd0), 0);
        chk("rst_core_ready", int'(ready0), 1);
        chk("rst_imem_we", int'(we0), 0);
        chk("rst_imem_addr", int'(addr0), 0);
        chk_v("rst_r0_data", r0d0, '0);
        chk("rst_task_hold", int'(hold0), 0);
        chk("rst_task_barrier", int'(bar0), 0);
        chk("rst_core_start", int'(start0), 0);
        chk("rst_err_mask", int'(errm0), 0);
        chk("rst_err_busy", int'(errb0), 0);
        @(negedge clk); reset = 1'b0;
        idle(3);

        // Table-driven whole tasks
        for (int r = 0; r < 5; r++) begin
            snap();
            send_task(r + 1, vecs[r].ctrl, vecs[r].m1, vecs[r].m2, 1'b0, -1);
            idle(5);
            chk($sformatf("row%0d_we0", r + 1), we0_tot - b_we0, vecs[r].we0);
            chk($sformatf("row%0d_we4", r + 1), we4_tot - b_we4, vecs[r].we4);
            chk($sformatf("row%0d_wr_seq", r + 1), bad_tot - b_bad, 0);
            chk($sformatf("row%0d_start0", r + 1), st0_tot - b_st0, vecs[r].st0);
            chk($sformatf("row%0d_start4", r + 1), st4_tot - b_st4, vecs[r].st4);
            chk($sformatf("row%0d_err_mask0", r + 1), em0_tot - b_em0, vecs[r].em0);
            chk($sformatf("row%0d_err_mask4", r + 1), em4_tot - b_em4, vecs[r].em4);
            chk($sformatf("row%0d_ready0", r + 1), int'(ready0), int'(vecs[r].rdy0));
            chk($sformatf("row%0d_barrier0", r + 1), int'(bar0), int'(vecs[r].bar0));
            if (vecs[r].st0 == 1)
                chk($sformatf("row%0d_start_latency", r + 1), start0_cyc - last_xfer, 2);
            if (vecs[r].chk_r0)
                chk_v($sformatf("row%0d_r0_data", r + 1), r0d0, exp_r0(r + 1));
            pulse_done();
            chk($sformatf("row%0d_ready_after_done", r + 1), int'(ready0), 1);
        end

        // Held task released by go
        snap();
        send_task(6, 16'h0043, 16'h0001, 16'h0001, 1'b0, -1);
        idle(4);
        chk("hold_task_hold", int'(hold0), 1);
        chk("hold_no_start", st0_tot - b_st0, 0);
        chk("hold_we0", we0_tot - b_we0, 48);
        chk("hold_ready", int'(ready0), 1);
        begin
            int gcyc;
            @(negedge clk); go = 1'b1; gcyc = cyc;
            @(negedge clk); go = 1'b0;
            @(negedge clk); #1;
            chk("go_start", st0_tot - b_st0, 1);
            chk("go_latency", start0_cyc - gcyc, 1);
        end
        chk("go_hold_cleared", int'(hold0), 0);
        chk("go_ready", int'(ready0), 0);
        pulse_done();
        chk("go_ready_after_done", int'(ready0), 1);

        // Busy core: second addressed task rejected, third accepted via done in MASK2
        send_task(7, 16'h0003, 16'h0001, 16'h0001, 1'b0, -1);
        idle(3);
        snap();
        send_task(8, 16'h0007, 16'h0001, 16'h0001, 1'b0, -1);
        idle(3);
        chk("busy_err_busy", int'(errb0), 1);
        chk("busy_no_writes", we0_tot - b_we0, 0);
        chk("busy_no_start", st0_tot - b_st0, 0);
        chk("busy_ready", int'(ready0), 0);
        snap();
        send_task(9, 16'h0001, 16'h0001, 16'h0001, 1'b1, -1);
        idle(4);
        chk("b2b_we0", we0_tot - b_we0, 16);
        chk("b2b_wr_seq", bad_tot - b_bad, 0);
        chk("b2b_start", st0_tot - b_st0, 1);
        chk("b2b_latency", start0_cyc - last_xfer, 2);
        chk("b2b_err_busy_sticky", int'(errb0), 1);
        pulse_done();

        // imem stall mid-instruction phase
        snap();
        rd_low = 0;
        send_task(10, 16'h0002, 16'h0001, 16'h0001, 1'b0, 10);
        idle(4);
        chk("stall_reading_low_cycles", rd_low, 5);
        chk("stall_we0", we0_tot - b_we0, 32);
        chk("stall_wr_seq", bad_tot - b_bad, 0);
        chk("stall_start", st0_tot - b_st0, 1);
        pulse_done();

        // Reset mid-instruction phase
        snap();
        cur_row = 11;
        send_frame(16'h0002, 1'b0, 0);
        send_frame(16'h0001, 1'b0, 0);
        send_frame(16'h0001, 1'b0, 0);
        for (int k = 0; k < 8; k++) send_frame(r0_word(11, k), 1'b0, 0);
        for (int i = 0; i < 5; i++) send_frame(instr_word(11, i), 1'b0, 0);
        @(negedge clk); fbs = 1'b0; reset = 1'b1;
        @(negedge clk); #1;
        chk("mid_rst_reading", int'(rd0), 0);
        chk("mid_rst_imem_we", int'(we0), 0);
        chk_v("mid_rst_r0_data", r0d0, '0);
        chk("mid_rst_ready", int'(ready0), 1);
        chk("mid_rst_err_busy", int'(errb0), 0);
        chk("mid_rst_wr_seq", bad_tot - b_bad, 0);
        @(negedge clk); reset = 1'b0;
        idle(20);
        chk("mid_rst_no_start", st0_tot - b_st0, 0);
        snap();
        send_task(12, 16'h0001, 16'h0001, 16'h0001, 1'b0, -1);
        idle(4);
        chk("post_rst_we0", we0_tot - b_we0, 16);
        chk("post_rst_wr_seq", bad_tot - b_bad, 0);
        chk("post_rst_start", st0_tot - b_st0, 1);
        chk_v("post_rst_r0_data", r0d0, exp_r0(12));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
